// File: rtl/dev_bridge.sv
// rtl/dev_bridge.sv - CPU data-port to memory-mapped device slot bridge
module dev_bridge #(
  parameter int          DEV_ADDR_WD = 2,
  parameter logic [31:0] BASE0       = 32'h0000_7F00,
  parameter logic [31:0] BASE1       = 32'h0000_7F10,
  parameter logic [31:0] BASE2       = 32'h0000_7F20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cpu_req_i,
  input  logic                   cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  input  logic [31:0]            cpu_dat_i,
  output logic [31:0]            cpu_dat_o,
  output logic                   cpu_ack_o,
  output logic                   cpu_err_o,
  output logic [2:0]             dev_we_o,
  output logic [DEV_ADDR_WD:1]   dev_add_o,
  output logic [31:0]            dev_dat_o,
  input  logic [31:0]            dev0_dat_i,
  input  logic [31:0]            dev1_dat_i,
  input  logic [31:0]            dev2_dat_i,
  input  logic [2:0]             dev_irq_i,
  output logic [2:0]             hwint_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        we_q;
  logic        err_q;
  logic [2:0]  slot_q;
  logic [2:0]  hit;
  logic        dec_err;
  logic [31:0] rd_mux;

  // Address decode: one-hot slot match plus unmapped/misaligned detection.
  // Word offset 3 is reserved in every slot (devices expose CTRL, PRESET, COUNT).
  always_comb begin
    hit     = 3'b000;
    hit[0]  = (cpu_addr_i[31:4] == BASE0[31:4]);
    hit[1]  = (cpu_addr_i[31:4] == BASE1[31:4]);
    hit[2]  = (cpu_addr_i[31:4] == BASE2[31:4]);
    dec_err = (hit == 3'b000) || (cpu_addr_i[1:0] != 2'b00) || (cpu_addr_i[3:2] == 2'b11);
  end

  // Read-data select from the slot latched at request time.
  always_comb begin
    rd_mux = 32'h0;
    if (slot_q[0])      rd_mux = dev0_dat_i;
    else if (slot_q[1]) rd_mux = dev1_dat_i;
    else if (slot_q[2]) rd_mux = dev2_dat_i;
  end

  // Transaction FSM: IDLE accepts, ACCESS drives the device bus for one cycle, RESP acks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      slot_q    <= 3'b000;
      cpu_dat_o <= 32'h0;
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
      dev_we_o  <= 3'b000;
      dev_add_o <= '0;
      dev_dat_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            we_q      <= cpu_we_i;
            err_q     <= dec_err;
            slot_q    <= hit;
            dev_add_o <= cpu_addr_i[DEV_ADDR_WD+1:2];
            dev_dat_o <= cpu_dat_i;
            // Faulty accesses never reach a device as a write.
            dev_we_o  <= (cpu_we_i && !dec_err) ? hit : 3'b000;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes and errors return zero so stale read data never leaks out.
          cpu_dat_o <= (!we_q && !err_q) ? rd_mux : 32'h0;
          cpu_ack_o <= 1'b1;
          cpu_err_o <= err_q;
          dev_we_o  <= 3'b000;
          dev_add_o <= '0;
          dev_dat_o <= 32'h0;
          state     <= RESP;
        end
        RESP: begin
          cpu_ack_o <= 1'b0;
          cpu_err_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt lines are registered once and forwarded regardless of bus activity.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hwint_o <= 3'b000;
    else       hwint_o <= dev_irq_i;
  end

endmodule

// File: tb/tb_dev_bridge.sv
// tb/tb_dev_bridge.sv - directed scoreboard bench for dev_bridge
module tb_dev_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_dat_i;
  logic [31:0] cpu_dat_o;
  logic        cpu_ack_o;
  logic        cpu_err_o;
  logic [2:0]  dev_we_o;
  logic [2:1]  dev_add_o;
  logic [31:0] dev_dat_o;
  logic [31:0] dev0_dat_i;
  logic [31:0] dev1_dat_i;
  logic [31:0] dev2_dat_i;
  logic [2:0]  dev_irq_i;
  logic [2:0]  hwint_o;

  dev_bridge dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_dat_i  (cpu_dat_i),
    .cpu_dat_o  (cpu_dat_o),
    .cpu_ack_o  (cpu_ack_o),
    .cpu_err_o  (cpu_err_o),
    .dev_we_o   (dev_we_o),
    .dev_add_o  (dev_add_o),
    .dev_dat_o  (dev_dat_o),
    .dev0_dat_i (dev0_dat_i),
    .dev1_dat_i (dev1_dat_i),
    .dev2_dat_i (dev2_dat_i),
    .dev_irq_i  (dev_irq_i),
    .hwint_o    (hwint_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic err, input logic [31:0] rd);
    exp_t e;
    e.err = err;
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=ack expected=no_pending_entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_err"}, 32'(cpu_err_o), 32'(e.err));
      check({tag, "_dat"}, cpu_dat_o, e.rd);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // One isolated transaction: device-side check after the request edge, ack at +2 edges.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] dat, input logic [2:0] exp_we,
                     input logic [1:0] exp_add, input logic exp_err,
                     input logic [31:0] exp_rd);
    sb_push(exp_err, exp_rd);
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_dat_i  = dat;
    tick();
    cpu_req_i = 1'b0;
    check({tag, "_acc_we"},  32'(dev_we_o),  32'(exp_we));
    check({tag, "_acc_add"}, 32'(dev_add_o), 32'(exp_add));
    check({tag, "_acc_dat"}, dev_dat_o, dat);
    check({tag, "_acc_ack"}, 32'(cpu_ack_o), 32'd0);
    tick();
    check({tag, "_rsp_ack"}, 32'(cpu_ack_o), 32'd1);
    check({tag, "_rsp_we"},  32'(dev_we_o),  32'd0);
    if (cpu_ack_o === 1'b1) sb_pop_check(tag);
    tick();
    check({tag, "_idle_ack"}, 32'(cpu_ack_o), 32'd0);
  endtask

  initial begin
    int ack_cnt;
    int ack_cyc[$];

    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0;
    cpu_dat_i  = 32'h0;
    dev0_dat_i = 32'h1111_0000;
    dev1_dat_i = 32'h8765_4321;
    dev2_dat_i = 32'h2222_2222;
    dev_irq_i  = 3'b000;
    tick();
    tick();
    check("rst_dat",   cpu_dat_o, 32'h0);
    check("rst_ack",   32'(cpu_ack_o), 32'd0);
    check("rst_err",   32'(cpu_err_o), 32'd0);
    check("rst_we",    32'(dev_we_o),  32'd0);
    check("rst_add",   32'(dev_add_o), 32'd0);
    check("rst_ddat",  dev_dat_o, 32'h0);
    check("rst_hwint", 32'(hwint_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Write CTRL of slot 0, then read PRESET of slot 1.
    txn("wr_ctrl", 1'b1, 32'h0000_7F00, 32'h0000_0009, 3'b001, 2'd0, 1'b0, 32'h0);
    txn("rd_pre1", 1'b0, 32'h0000_7F14, 32'hDEAD_BEEF, 3'b000, 2'd1, 1'b0, 32'h8765_4321);

    // Error cases: unmapped window, reserved offset 3, misaligned.
    txn("err_unm", 1'b1, 32'h0000_7F30, 32'h0000_00A5, 3'b000, 2'd0, 1'b1, 32'h0);
    txn("err_off", 1'b1, 32'h0000_7F0C, 32'h0000_00A6, 3'b000, 2'd3, 1'b1, 32'h0);
    txn("err_mis", 1'b1, 32'h0000_7F02, 32'h0000_00A7, 3'b000, 2'd0, 1'b1, 32'h0);

    // A read after an error must load fresh data again.
    txn("rd_cnt2", 1'b0, 32'h0000_7F28, 32'h0, 3'b000, 2'd2, 1'b0, 32'h2222_2222);

    // Back-to-back: request held 6 cycles, address alternating slot0/slot2 every cycle.
    sb_push(1'b0, 32'h1111_0000);
    sb_push(1'b0, 32'h2222_2222);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_7F00;
    ack_cnt    = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k < 5) cpu_addr_i = (k % 2 == 0) ? 32'h0000_7F28 : 32'h0000_7F00;
      else       cpu_req_i  = 1'b0;
      if (cpu_ack_o === 1'b1) begin
        ack_cnt++;
        ack_cyc.push_back(k);
        sb_pop_check("b2b");
      end
    end
    check("b2b_count", 32'(ack_cnt), 32'd2);
    if (ack_cyc.size() == 2) check("b2b_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    check("b2b_first", (ack_cyc.size() > 0) ? 32'(ack_cyc[0]) : 32'hFFFF_FFFF, 32'd1);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during ACCESS of a write to slot 2.
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 32'h0000_7F24;
    cpu_dat_i  = 32'h0000_0055;
    tick();
    cpu_req_i = 1'b0;
    check("rstacc_we_pre", 32'(dev_we_o), 32'b100);
    #1;
    rst_i = 1'b1;
    #1;
    check("rstacc_we",   32'(dev_we_o),  32'd0);
    check("rstacc_add",  32'(dev_add_o), 32'd0);
    check("rstacc_ddat", dev_dat_o, 32'h0);
    check("rstacc_ack",  32'(cpu_ack_o), 32'd0);
    check("rstacc_dat",  cpu_dat_o, 32'h0);
    #1;
    rst_i = 1'b0;
    tick();
    check("rstacc_noack1", 32'(cpu_ack_o), 32'd0);
    tick();
    check("rstacc_noack2", 32'(cpu_ack_o), 32'd0);
    txn("post_rst", 1'b1, 32'h0000_7F24, 32'h0000_0077, 3'b100, 2'd1, 1'b0, 32'h0);

    // Interrupt forwarded while a read is in flight.
    sb_push(1'b0, 32'h1111_0000);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_7F08;
    tick();
    cpu_req_i = 1'b0;
    dev_irq_i = 3'b100;
    check("irq_pre", 32'(hwint_o), 32'd0);
    check("irq_acc_add", 32'(dev_add_o), 32'd2);
    tick();
    check("irq_hi", 32'(hwint_o), 32'b100);
    check("irq_ack", 32'(cpu_ack_o), 32'd1);
    if (cpu_ack_o === 1'b1) sb_pop_check("irq_rd");
    dev_irq_i = 3'b000;
    tick();
    check("irq_lo", 32'(hwint_o), 32'd0);
    check("irq_ack_end", 32'(cpu_ack_o), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
